// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with registered read data and overflow/underflow status flags.
// Ports:
//     clk       - system clock, all state updates on the rising edge
//     reset     - synchronous active-low reset
//     read_en   - read request
//     write_en  - write request
//     data_in   - write data, captured on an accepted write
//     data_out  - registered read data, holds when no read is accepted
//     overflow  - write rejected because the FIFO was full
//     underflow - read rejected because the FIFO was empty
// Build option FIFO_STICKY_FLAGS_EN: overflow/underflow stay set until reset instead of pulsing.
module sync_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              overflow,
    output logic              underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              full, empty, wr_acc, rd_acc, ovf_ev, unf_ev;
    always_comb begin
        full     = count_q == FULL_CNT;
        empty    = count_q == '0;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_acc   = write_en && (!full || read_en);
        rd_acc   = read_en && !empty;
        ovf_ev   = write_en && full && !read_en;
        unf_ev   = read_en && empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                   (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
        data_d   = rd_acc ? mem_q[rd_ptr_q] : data_q;
`ifdef FIFO_STICKY_FLAGS_EN
        ovf_d    = ovf_q || ovf_ev;
        unf_d    = unf_q || unf_ev;
`else
        ovf_d    = ovf_ev;
        unf_d    = unf_ev;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end
    assign data_out  = data_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_sync_byte_fifo.sv
// tb_sync_byte_fifo: directed self-checking bench for sync_byte_fifo.
module tb_sync_byte_fifo;
`ifdef FIFO_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read_en = 1'b0;
    logic       write_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       overflow, underflow;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         ovf_seen = 1'b0;
    bit         unf_seen = 1'b0;

    sync_byte_fifo dut (
        .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic we, input logic re, input logic [7:0] din);
        write_en = we;
        read_en  = re;
        data_in  = din;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Expected flags: the event pulse, or a held value once seen in a sticky build.
    task automatic flags(input string tag, input bit ev_o, input bit ev_u);
        ovf_seen |= ev_o;
        unf_seen |= ev_u;
        chk({tag, "_ovf"}, {7'd0, overflow}, {7'd0, ev_o | (STICKY & ovf_seen)});
        chk({tag, "_unf"}, {7'd0, underflow}, {7'd0, ev_u | (STICKY & unf_seen)});
    endtask

    initial begin
        // Reset
        step(0, 0, 8'h00);
        chk("rst_data", data_out, 8'h00);
        flags("rst", 0, 0);
        reset = 1'b1;
        // Single transfer
        step(1, 0, 8'h0A);
        flags("wr1", 0, 0);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        chk("single_rd", data_out, 8'h0A);
        flags("single_rd", 0, 0);
        // Multi-write ordering
        step(1, 0, 8'h0A);
        step(1, 0, 8'h1B);
        step(0, 1, 8'h00);
        chk("ord_rd0", data_out, 8'h0A);
        step(0, 1, 8'h00);
        chk("ord_rd1", data_out, 8'h1B);
        flags("ord", 0, 0);
        // Underflow from empty
        step(0, 1, 8'h00);
        flags("unf", 0, 1);
        chk("unf_hold", data_out, 8'h1B);
        step(0, 0, 8'h00);
        flags("unf_after", 0, 0);
        // Overflow
        step(1, 0, 8'h0A);
        step(1, 0, 8'h1B);
        step(1, 0, 8'h2C);
        step(1, 0, 8'h3D);
        flags("fill4", 0, 0);
        step(1, 0, 8'h4E);
        flags("ovf", 1, 0);
        step(0, 0, 8'h00);
        flags("ovf_after", 0, 0);
        step(0, 1, 8'h00);
        chk("ovf_rd0", data_out, 8'h0A);
        step(0, 1, 8'h00);
        chk("ovf_rd1", data_out, 8'h1B);
        step(0, 1, 8'h00);
        chk("ovf_rd2", data_out, 8'h2C);
        step(0, 1, 8'h00);
        chk("ovf_rd3", data_out, 8'h3D);
        step(0, 1, 8'h00);
        flags("ovf_empty", 0, 1);
        chk("ovf_empty_hold", data_out, 8'h3D);
        // Alternating write/read across pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(1, 0, (i % 2 == 0) ? 8'h0A : 8'h1B);
            step(0, 1, 8'h00);
            chk($sformatf("wrap_rd%0d", i), data_out, (i % 2 == 0) ? 8'h0A : 8'h1B);
        end
        flags("wrap", 0, 0);
        // Simultaneous read+write at full
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        step(1, 1, 8'h55);
        chk("full_rw_rd", data_out, 8'h11);
        flags("full_rw", 0, 0);
        step(0, 1, 8'h00);
        chk("full_rw_rd1", data_out, 8'h22);
        step(0, 1, 8'h00);
        chk("full_rw_rd2", data_out, 8'h33);
        step(0, 1, 8'h00);
        chk("full_rw_rd3", data_out, 8'h44);
        step(0, 1, 8'h00);
        chk("full_rw_rd4", data_out, 8'h55);
        flags("full_rw_drain", 0, 0);
        // Simultaneous read+write at empty: write only, no bypass
        step(1, 1, 8'h66);
        flags("empty_rw", 0, 1);
        chk("empty_rw_hold", data_out, 8'h55);
        step(0, 1, 8'h00);
        chk("empty_rw_rd", data_out, 8'h66);
        flags("empty_rw_rd", 0, 0);
        // Reset mid-operation with three entries stored
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        flags("pre_rst", 0, 0);
        reset = 1'b0;
        step(0, 0, 8'h00);
        reset = 1'b1;
        ovf_seen = 1'b0;
        unf_seen = 1'b0;
        chk("mid_rst_data", data_out, 8'h00);
        flags("mid_rst", 0, 0);
        step(0, 1, 8'h00);
        flags("mid_rst_rd", 0, 1);
        chk("mid_rst_rd_data", data_out, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_byte_fifo.md
Name: sync_byte_fifo

Overview:
- Single-clock, synchronous first-in/first-out buffer for 8-bit data, DEPTH entries, with registered read data.
- Sits between a byte producer and consumer in the same clock domain.
- Flags rejected writes (overflow) and rejected reads (underflow) with status pulses.
- Internally: storage array, write/read pointers, occupancy counter, flag logic.

Parameters:
- DATA_W, 8, data width in bits.
- DEPTH, 4, number of storage entries; power of two, minimum 2.
- PTR_W, log2(DEPTH) = 2, pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- read_en  input  1  read request, sampled each rising edge.
- write_en  input  1  write request, sampled each rising edge.
- data_in  input  DATA_W  write data, captured when a write is accepted.
- data_out  output  DATA_W  registered read data.
- overflow  output  1  write rejected because the FIFO was full.
- underflow  output  1  read rejected because the FIFO was empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, overflow=0, underflow=0.
  - Storage contents are don't-care.
  - Reset has priority over any read_en/write_en in the same cycle.
  - Reset mid-operation discards all stored data.
- Internal status: full = (count==DEPTH); empty = (count==0), both evaluated from pre-edge state.
- Write accepted when write_en=1 and (!full, or full with read_en=1):
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
- Read accepted when read_en=1 and !empty:
  - data_out <= mem[rd_ptr] one cycle after the request edge (latency 1).
  - rd_ptr increments and wraps.
- data_out holds its last value when no read is accepted, including on a rejected read.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous accepted read+write.
- Full with read and write together: both accepted; the oldest entry is read; no overflow.
- Empty with read and write together: write accepted, read rejected, underflow=1. No fall-through bypass: data becomes readable the following cycle.
- overflow: registered, =1 for exactly the cycle after each edge where write_en=1, full, and read_en=0; otherwise 0. The rejected write changes no state.
- underflow: registered, =1 for the cycle after each edge where read_en=1 and empty; otherwise 0. Pointers unchanged.
- Consecutive rejected attempts produce consecutive high cycles.
- Ordering: strict FIFO; data read in write order across pointer wrap-around.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIFO_STICKY_FLAGS_EN.
- When defined:
  - overflow and underflow are sticky: set by the same conditions as the base behaviour.
  - Once set, they remain 1 until synchronous reset.
- When undefined: both are single-cycle pulses as specified in Behaviour.

Test Plan:
- Reset then single transfer:
  - reset=0 one edge, then reset=1; write 0x0A one cycle; idle two cycles; read one cycle.
  - Required: data_out=0x0A one cycle after the read edge; no flags; FIFO empty afterwards.
- Multi-write ordering:
  - Write 0x0A then 0x1B on back-to-back cycles; read twice.
  - Required: data_out 0x0A then 0x1B; FIFO empty afterwards.
- Underflow:
  - From empty, read_en=1 for one cycle.
  - Required: underflow=1 for one cycle; data_out keeps its previous value (0x1B); pointers unchanged.
- Overflow:
  - From empty, write 0x0A, 0x1B, 0x2C, 0x3D, 0x4E on consecutive cycles.
  - Required: first four accepted; overflow=1 for one cycle after the 0x4E edge.
  - Four subsequent reads return 0x0A, 0x1B, 0x2C, 0x3D.
- Wrap and simultaneous access:
  - Alternate write 0x0A/read, write 0x1B/read for more than DEPTH iterations; then fill to 4 entries and assert read_en+write_en together.
  - Required: correct data across pointer wrap; at full, oldest entry out, new data stored, count stays 4, no overflow.
- Reset mid-operation:
  - With 3 entries stored, reset=0 one edge.
  - Required: data_out=0 and flags 0; an immediate read gives underflow=1.
  - With FIFO_STICKY_FLAGS_EN defined, an earlier overflow stays 1 until this reset.
